path_stream_tx: RTL and testbench

- Transmitter for the antenna path interface (txant / tdata / tfram). It produces the stream that the downlink path consumes as its fdata / ffram / fxant inputs.
- It accepts antenna-ordered 32-bit IQ words over a valid/ready input and buffers them in a FIFO.
- It emits continuous antenna-interleaved frames aligned to a frame sync pulse.
- It keeps antenna-slot alignment on underrun by substituting zeros and flagging the event.

---
 rtl/path_stream_pkg.sv | 34 +++
 rtl/path_stream_fifo.sv | 58 +++++
 rtl/path_stream_tx.sv | 163 ++++++++++++++++
 tb/tb_path_stream_tx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/path_stream_pkg.sv
// Shared types and constants for the antenna-path stream transmitter.
// The test-pattern field layout is used only when PATH_STREAM_TX_TESTPAT_EN is defined.
package path_stream_pkg;

   localparam int unsigned PATH_DW     = 32;
   localparam int unsigned SLOT_W      = 16;
   localparam int unsigned TP_ANT_LSB  = 28;
   localparam int unsigned TP_ANT_W    = 4;
   localparam int unsigned TP_SLOT_LSB = 0;
   localparam int unsigned TP_SLOT_W   = 16;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_SYNC = 2'd1,
      RUN       = 2'd2
   } state_t;

   typedef struct packed {
      logic               txant;
      logic               tfram;
      logic [PATH_DW-1:0] data;
   } path_word_t;

   // Test-pattern word: antenna index in the top nibble, slot counter in the low half.
   function automatic logic [PATH_DW-1:0] tp_word(input logic [TP_ANT_W-1:0]  ant,
                                                  input logic [TP_SLOT_W-1:0] slot);
      logic [PATH_DW-1:0] w;
      w = '0;
      w[TP_ANT_LSB  +: TP_ANT_W]  = ant;
      w[TP_SLOT_LSB +: TP_SLOT_W] = slot;
      return w;
   endfunction

endpackage

// File: rtl/path_stream_fifo.sv
// Synchronous first-word-fall-through FIFO with synchronous flush.
// A push while full is accepted when a pop happens in the same cycle.
module path_stream_fifo
   import path_stream_pkg::*;
#(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned DW    = PATH_DW
) (
   input  logic                   clk,
   input  logic                   asy_rst,
   input  logic                   i_push,
   input  logic [DW-1:0]          i_data,
   input  logic                   i_pop,
   input  logic                   i_flush,
   output logic [DW-1:0]          o_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [LW-1:0] r_level;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_empty   = (r_level == '0);
   assign o_full    = (r_level == LW'(DEPTH));
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_data    = r_mem[r_rd];
   assign o_level   = r_level;

   always_ff @(posedge clk or negedge asy_rst) begin
      if (!asy_rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_level <= '0;
      end else if (i_flush) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_level <= '0;
      end else begin
         if (w_do_push) r_wr <= r_wr + AW'(1);
         if (w_do_pop)  r_rd <= r_rd + AW'(1);
         r_level <= r_level + LW'(w_do_push) - LW'(w_do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush) r_mem[r_wr] <= i_data;
   end

endmodule

// File: rtl/path_stream_tx.sv
// Antenna-path stream transmitter: FIFO-buffered IQ words emitted as sync-aligned,
// antenna-interleaved frames. Define PATH_STREAM_TX_TESTPAT_EN to add the i_test_sel pattern source.
module path_stream_tx
   import path_stream_pkg::*;
#(
   parameter int unsigned N_ANT      = 8,
   parameter int unsigned FRAME_LEN  = 1920,
   parameter int unsigned FIFO_DEPTH = 64,
   parameter int unsigned PREFILL    = 16
) (
   input  logic               clk,
   input  logic               asy_rst,
   input  logic               i_en,
   input  logic               i_frame_sync,
   input  logic [PATH_DW-1:0] s_data,
   input  logic               s_valid,
   output logic               s_ready,
   output logic               o_path_txant,
   output logic [PATH_DW-1:0] o_path_tdata,
   output logic               o_path_tfram,
   output logic               o_underrun,
   output logic               o_sync_err,
   input  logic               i_err_clr,
   output logic [15:0]        o_frame_cnt,
`ifdef PATH_STREAM_TX_TESTPAT_EN
   input  logic               i_test_sel,
`endif
   output logic               o_busy
);

   localparam int unsigned ANT_W = $clog2(N_ANT);
   localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

   state_t             r_state, w_state_nxt;
   logic [ANT_W-1:0]   r_ant, w_ant_nxt;
   logic [SLOT_W-1:0]  r_slot, w_slot_nxt;
   path_word_t         r_path, w_path_nxt;
   logic               r_out_last, w_out_last_nxt;
   logic               r_busy;
   logic               r_underrun, r_sync_err;
   logic [15:0]        r_frame_cnt;

   logic               w_emit, w_last, w_flush, w_frame_done, w_serr_set;
   logic               w_tp, w_pop, w_push, w_udr_set;
   logic               w_full, w_empty;
   logic [PATH_DW-1:0] w_fifo_data;
   logic [LVL_W-1:0]   w_level;

`ifdef PATH_STREAM_TX_TESTPAT_EN
   assign w_tp = i_test_sel;
`else
   assign w_tp = 1'b0;
`endif

   assign w_pop     = w_emit && !w_tp && !w_empty;
   assign w_udr_set = w_emit && !w_tp && w_empty;
   assign s_ready   = (r_state != IDLE) && (!w_full || w_pop);
   assign w_push    = s_valid && s_ready;

   path_stream_fifo #(
      .DEPTH (FIFO_DEPTH),
      .DW    (PATH_DW)
   ) u_fifo (
      .clk     (clk),
      .asy_rst (asy_rst),
      .i_push  (w_push),
      .i_data  (s_data),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .o_data  (w_fifo_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   // Next state, slot/antenna position and the word registered onto the path.
   always_comb begin
      w_state_nxt    = r_state;
      w_ant_nxt      = r_ant;
      w_slot_nxt     = r_slot;
      w_path_nxt     = '0;
      w_out_last_nxt = 1'b0;
      w_emit         = 1'b0;
      w_flush        = 1'b0;
      w_frame_done   = 1'b0;
      w_serr_set     = 1'b0;
      w_last         = (r_ant == ANT_W'(N_ANT - 1)) && (r_slot == SLOT_W'(FRAME_LEN - 1));

      case (r_state)
         IDLE: begin
            w_flush    = 1'b1;
            w_ant_nxt  = '0;
            w_slot_nxt = '0;
            if (i_en) w_state_nxt = WAIT_SYNC;
         end
         WAIT_SYNC: begin
            if (!i_en) begin
               w_state_nxt = IDLE;
            end else if (i_frame_sync && (w_level >= LVL_W'(PREFILL))) begin
               w_emit      = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            w_emit = 1'b1;
            // A sync is aligned only while the previous frame's last word is on the outputs.
            if (i_frame_sync && !r_out_last) w_serr_set = 1'b1;
            if (w_last) begin
               w_frame_done = 1'b1;
               if (!i_en) w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      if (w_emit) begin
         if (r_ant == ANT_W'(N_ANT - 1)) begin
            w_ant_nxt  = '0;
            w_slot_nxt = w_last ? '0 : r_slot + SLOT_W'(1);
         end else begin
            w_ant_nxt  = r_ant + ANT_W'(1);
         end
         w_path_nxt.txant = (r_ant >= ANT_W'(N_ANT / 2));
         w_path_nxt.tfram = (r_ant == '0) && (r_slot == '0);
         w_path_nxt.data  = w_tp    ? tp_word(TP_ANT_W'(r_ant), r_slot) :
                            w_empty ? '0 : w_fifo_data;
         w_out_last_nxt   = w_last;
      end
   end

   always_ff @(posedge clk or negedge asy_rst) begin
      if (!asy_rst) begin
         r_state     <= IDLE;
         r_ant       <= '0;
         r_slot      <= '0;
         r_path      <= '0;
         r_out_last  <= 1'b0;
         r_busy      <= 1'b0;
         r_underrun  <= 1'b0;
         r_sync_err  <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_ant      <= w_ant_nxt;
         r_slot     <= w_slot_nxt;
         r_path     <= w_path_nxt;
         r_out_last <= w_out_last_nxt;
         r_busy     <= (w_state_nxt == RUN);
         r_underrun <= w_udr_set  ? 1'b1 : (i_err_clr ? 1'b0 : r_underrun);
         r_sync_err <= w_serr_set ? 1'b1 : (i_err_clr ? 1'b0 : r_sync_err);
         if (w_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   assign o_path_txant = r_path.txant;
   assign o_path_tfram = r_path.tfram;
   assign o_path_tdata = r_path.data;
   assign o_underrun   = r_underrun;
   assign o_sync_err   = r_sync_err;
   assign o_frame_cnt  = r_frame_cnt;
   assign o_busy       = r_busy;

endmodule

// File: tb/tb_path_stream_tx.sv
// Self-checking bench for path_stream_tx (N_ANT=8, FRAME_LEN=4, PREFILL=8, FIFO_DEPTH=64).
// Test-pattern sequence is included when PATH_STREAM_TX_TESTPAT_EN is defined.
module tb_path_stream_tx;

   localparam int N_ANT     = 8;
   localparam int FRAME_LEN = 4;
   localparam int WPF       = N_ANT * FRAME_LEN;

   logic        clk = 1'b0;
   logic        asy_rst;
   logic        i_en, i_frame_sync, s_valid, i_err_clr;
   logic [31:0] s_data;
   logic        s_ready, o_path_txant, o_path_tfram, o_underrun, o_sync_err, o_busy;
   logic [31:0] o_path_tdata;
   logic [15:0] o_frame_cnt;
`ifdef PATH_STREAM_TX_TESTPAT_EN
   logic        i_test_sel;
   int          tp_words;
`endif

   int          checks;
   int          errs;
   int          ready_drops;
   logic        stream;
   logic        last_hs;
   logic [31:0] sb[$];

   typedef struct {
      logic sync;
      logic en;
      logic fram;
      logic txant;
      logic busy_chk;
      logic busy;
      logic word;
   } vec_t;
   vec_t tbl[WPF + 1];

   path_stream_tx #(
      .N_ANT(N_ANT), .FRAME_LEN(FRAME_LEN), .FIFO_DEPTH(64), .PREFILL(8)
   ) dut (
      .clk(clk), .asy_rst(asy_rst), .i_en(i_en), .i_frame_sync(i_frame_sync),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .o_path_txant(o_path_txant), .o_path_tdata(o_path_tdata), .o_path_tfram(o_path_tfram),
      .o_underrun(o_underrun), .o_sync_err(o_sync_err), .i_err_clr(i_err_clr),
      .o_frame_cnt(o_frame_cnt),
`ifdef PATH_STREAM_TX_TESTPAT_EN
      .i_test_sel(i_test_sel),
`endif
      .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   // Scoreboard fill: every accepted input word is expected on the path in order.
   always @(posedge clk) begin
      if (asy_rst && s_valid && s_ready) sb.push_back(s_data);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      last_hs = s_valid && s_ready;
      if (s_valid && !s_ready) ready_drops++;
      @(posedge clk);
      #1;
      if (stream && last_hs) s_data = s_data + 32'd1;
   endtask

   task automatic push_words(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         s_valid = 1'b1;
         s_data  = base + 32'(i);
         tick();
      end
      s_valid = 1'b0;
   endtask

   // Word k of a sync-started stream: framing from k, data from scoreboard or zero on underrun.
   task automatic run_words(input int k0, input int k1, input int sync_k, input int clr_k,
                            input int drop_k);
      logic [31:0] exp;
      for (int k = k0; k < k1; k++) begin
         tick();
`ifdef PATH_STREAM_TX_TESTPAT_EN
         if (k < tp_words) exp = {4'(k % N_ANT), 12'h000, 16'((k / N_ANT) % FRAME_LEN)};
         else
`endif
         if (sb.size() > 0) exp = sb.pop_front();
         else exp = 32'h0;
         chk($sformatf("tdata[k=%0d]", k), o_path_tdata, exp);
         chk($sformatf("tfram[k=%0d]", k), 32'(o_path_tfram), 32'((k % WPF) == 0));
         chk($sformatf("txant[k=%0d]", k), 32'(o_path_txant), 32'((k % N_ANT) >= N_ANT / 2));
         i_frame_sync = (k == sync_k);
         i_err_clr    = (k == clr_k);
         if (k == drop_k) i_en = 1'b0;
`ifdef PATH_STREAM_TX_TESTPAT_EN
         i_test_sel = (k + 1 < tp_words);
`endif
      end
      i_frame_sync = 1'b0;
      i_err_clr    = 1'b0;
   endtask

   initial begin
      checks = 0; errs = 0; ready_drops = 0; stream = 1'b0; last_hs = 1'b0;
      asy_rst = 1'b0; i_en = 1'b0; i_frame_sync = 1'b0; s_valid = 1'b0;
      i_err_clr = 1'b0; s_data = '0;
`ifdef PATH_STREAM_TX_TESTPAT_EN
      i_test_sel = 1'b0; tp_words = 0;
`endif

      for (int k = 0; k <= WPF; k++) begin
         tbl[k].sync     = (k == 0);
         tbl[k].en       = (k <= 5);
         tbl[k].fram     = (k == 0);
         tbl[k].txant    = (k < WPF) && ((k % N_ANT) >= N_ANT / 2);
         tbl[k].busy_chk = (k != WPF - 1);
         tbl[k].busy     = (k < WPF - 1);
         tbl[k].word     = (k < WPF);
      end

      // Reset state
      #23;
      chk("rst tdata", o_path_tdata, 32'h0);
      chk("rst tfram", 32'(o_path_tfram), 32'h0);
      chk("rst txant", 32'(o_path_txant), 32'h0);
      chk("rst s_ready", 32'(s_ready), 32'h0);
      chk("rst busy", 32'(o_busy), 32'h0);
      chk("rst underrun", 32'(o_underrun), 32'h0);
      chk("rst sync_err", 32'(o_sync_err), 32'h0);
      chk("rst frame_cnt", 32'(o_frame_cnt), 32'h0);
      asy_rst = 1'b1;

      // Test 1: one full frame from table, en dropped mid-frame
      i_en = 1'b1;
      tick();
      push_words(32, 32'h0);
      for (int k = 0; k <= WPF; k++) begin
         logic [31:0] exp;
         i_frame_sync = tbl[k].sync;
         i_en         = tbl[k].en;
         tick();
         i_frame_sync = 1'b0;
         if (tbl[k].word && sb.size() > 0) exp = sb.pop_front();
         else exp = 32'h0;
         chk($sformatf("t1 tdata[%0d]", k), o_path_tdata, exp);
         chk($sformatf("t1 tfram[%0d]", k), 32'(o_path_tfram), 32'(tbl[k].fram));
         chk($sformatf("t1 txant[%0d]", k), 32'(o_path_txant), 32'(tbl[k].txant));
         if (tbl[k].busy_chk) chk($sformatf("t1 busy[%0d]", k), 32'(o_busy), 32'(tbl[k].busy));
      end
      chk("t1 frame_cnt", 32'(o_frame_cnt), 32'd1);
      chk("t1 underrun", 32'(o_underrun), 32'h0);
      chk("t1 sync_err", 32'(o_sync_err), 32'h0);

      // Test 2: sync below prefill ignored; later run underruns after 8 words
      i_en = 1'b1;
      tick();
      push_words(5, 32'h100);
      i_frame_sync = 1'b1;
      tick();
      i_frame_sync = 1'b0;
      chk("t2 early sync busy", 32'(o_busy), 32'h0);
      chk("t2 early sync tfram", 32'(o_path_tfram), 32'h0);
      tick();
      chk("t2 still waiting", 32'(o_busy), 32'h0);
      chk("t2 no flag", 32'(o_sync_err), 32'h0);
      push_words(3, 32'h105);
      i_frame_sync = 1'b1;
      run_words(0, 64, -1, -1, 40);
      chk("t2 underrun", 32'(o_underrun), 32'h1);
      chk("t2 frame_cnt", 32'(o_frame_cnt), 32'd3);
      i_err_clr = 1'b1;
      tick();
      i_err_clr = 1'b0;
      chk("t2 underrun clr", 32'(o_underrun), 32'h0);

      // Test 3: misaligned sync sets error, aligned sync does not, clear works
      i_en = 1'b1;
      tick();
      push_words(64, 32'h200);
      chk("t3 full s_ready", 32'(s_ready), 32'h0);
      i_frame_sync = 1'b1;
      #1;
      chk("t3 full+pop s_ready", 32'(s_ready), 32'h1);
      run_words(0, 15, 10, -1, -1);
      chk("t3 sync_err set", 32'(o_sync_err), 32'h1);
      run_words(15, 25, -1, 16, -1);
      chk("t3 sync_err clr", 32'(o_sync_err), 32'h0);
      run_words(25, 40, 31, -1, 35);
      chk("t3 aligned no err", 32'(o_sync_err), 32'h0);
      run_words(40, 64, -1, -1, -1);
      chk("t3 busy end", 32'(o_busy), 32'h0);
      chk("t3 frame_cnt", 32'(o_frame_cnt), 32'd5);
      chk("t3 underrun", 32'(o_underrun), 32'h0);

      // Test 4: continuously valid source over three frames
      i_en = 1'b1;
      tick();
      ready_drops = 0;
      stream  = 1'b1;
      s_valid = 1'b1;
      s_data  = 32'h300;
      for (int i = 0; i < 8; i++) tick();
      i_frame_sync = 1'b1;
      run_words(0, 3 * WPF, -1, -1, 2 * WPF + 5);
      stream  = 1'b0;
      s_valid = 1'b0;
      chk("t4 ready drops", 32'(ready_drops), 32'h0);
      chk("t4 underrun", 32'(o_underrun), 32'h0);
      chk("t4 frame_cnt", 32'(o_frame_cnt), 32'd8);
      tick();
      sb.delete();
      chk("t4 idle busy", 32'(o_busy), 32'h0);
      chk("t4 idle tdata", o_path_tdata, 32'h0);
      chk("t4 idle tfram", 32'(o_path_tfram), 32'h0);
      chk("t4 idle txant", 32'(o_path_txant), 32'h0);

      // Test 5: asynchronous reset mid-frame
      i_en = 1'b1;
      tick();
      push_words(16, 32'h500);
      i_frame_sync = 1'b1;
      run_words(0, 5, -1, -1, -1);
      #3;
      asy_rst = 1'b0;
      #1;
      chk("t5 rst tdata", o_path_tdata, 32'h0);
      chk("t5 rst txant", 32'(o_path_txant), 32'h0);
      chk("t5 rst busy", 32'(o_busy), 32'h0);
      chk("t5 rst s_ready", 32'(s_ready), 32'h0);
      chk("t5 rst frame_cnt", 32'(o_frame_cnt), 32'h0);
      #2;
      asy_rst = 1'b1;
      sb.delete();
      tick();
      tick();
      chk("t5 wait busy", 32'(o_busy), 32'h0);
      chk("t5 wait s_ready", 32'(s_ready), 32'h1);
      i_frame_sync = 1'b1;
      tick();
      i_frame_sync = 1'b0;
      chk("t5 empty sync busy", 32'(o_busy), 32'h0);
      chk("t5 empty sync tfram", 32'(o_path_tfram), 32'h0);

`ifdef PATH_STREAM_TX_TESTPAT_EN
      // Test 6: test pattern frame leaves FIFO untouched
      push_words(8, 32'h600);
      tp_words     = WPF;
      i_test_sel   = 1'b1;
      i_frame_sync = 1'b1;
      run_words(0, WPF, -1, -1, -1);
      chk("t6 no underrun", 32'(o_underrun), 32'h0);
      run_words(WPF, 2 * WPF, -1, -1, WPF + 8);
      chk("t6 underrun after fifo", 32'(o_underrun), 32'h1);
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
